// File: rtl/gprfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : gprfile_mp
// Purpose  : Multi-port register file with per-register busy scoreboard,
//            optional write-to-read bypass and hardwired-zero register 0.
// Revision : 1.0 - initial release
// ============================================================================
module gprfile_mp #(
    parameter int XLEN    = 32,
    parameter int NREG    = 32,
    parameter int NRD     = 2,
    parameter int NWR     = 2,
    parameter int BYPASS  = 1,
    parameter int ZERO_R0 = 1,
    localparam int AW     = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   rd_num,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_num,
    input  logic [NWR*XLEN-1:0] wr_data,
    input  logic                iss_en,
    input  logic [AW-1:0]       iss_num,
    input  logic                flush,
    output logic                err_multiwr
);

    logic [XLEN-1:0] r_regs [NREG];
    logic [NREG-1:0] r_busy;
    logic            r_err;

    logic [NREG-1:0] w_we;
    logic [XLEN-1:0] w_wd [NREG];
    logic [NREG-1:0] w_set;
    logic            w_coll;

    // Per-register write resolution: scanning ports upward lets the highest
    // enabled port win, and a second hit on the same register flags a collision.
    always_comb begin
        w_we   = '0;
        w_set  = '0;
        w_coll = 1'b0;
        for (int r = 0; r < NREG; r++) begin
            w_wd[r] = '0;
            if (!(ZERO_R0 != 0 && r == 0)) begin
                for (int p = 0; p < NWR; p++) begin
                    if (wr_en[p] && (wr_num[p*AW +: AW] == AW'(r))) begin
                        if (w_we[r]) begin
                            w_coll = 1'b1;
                        end
                        w_we[r] = 1'b1;
                        w_wd[r] = wr_data[p*XLEN +: XLEN];
                    end
                end
                w_set[r] = iss_en && (iss_num == AW'(r));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                r_regs[r] <= '0;
            end
            r_busy <= '0;
            r_err  <= 1'b0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                if (w_we[r]) begin
                    r_regs[r] <= w_wd[r];
                end
            end
            // A new producer issued alongside a completing write keeps the bit set.
            if (flush) begin
                r_busy <= '0;
            end else begin
                r_busy <= (r_busy & ~w_we) | w_set;
            end
            r_err <= r_err | w_coll;
        end
    end

    assign err_multiwr = r_err;

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]   w_idx;
        logic [XLEN-1:0] w_data;
        logic            w_busy;

        assign w_idx = rd_num[k*AW +: AW];

        always_comb begin
            w_data = r_regs[w_idx];
            w_busy = r_busy[w_idx];
            if (BYPASS != 0 && w_we[w_idx]) begin
                w_data = w_wd[w_idx];
                w_busy = 1'b0;
            end
            if (ZERO_R0 != 0 && w_idx == '0) begin
                w_data = '0;
                w_busy = 1'b0;
            end
        end

        assign rd_data[k*XLEN +: XLEN] = w_data;
        assign rd_busy[k]              = w_busy;
    end

endmodule
`default_nettype wire

// File: tb/tb_gprfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : tb_gprfile_mp
// Purpose  : Self-checking bench for gprfile_mp against an array-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gprfile_mp;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int NRD  = 2;
    localparam int NWR  = 2;
    localparam int AW   = $clog2(NREG);

    logic                clk = 1'b0;
    logic                rst;
    logic [NRD*AW-1:0]   rd_num;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic [NWR-1:0]      wr_en;
    logic [NWR*AW-1:0]   wr_num;
    logic [NWR*XLEN-1:0] wr_data;
    logic                iss_en;
    logic [AW-1:0]       iss_num;
    logic                flush;
    logic                err_multiwr;

    int vectors     = 0;
    int miscompares = 0;

    logic [XLEN-1:0] model_regs [NREG];
    logic            model_busy [NREG];
    logic            model_err;

    gprfile_mp #(
        .XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR), .BYPASS(1), .ZERO_R0(1)
    ) dut (
        .clk(clk), .rst(rst), .rd_num(rd_num), .rd_data(rd_data), .rd_busy(rd_busy),
        .wr_en(wr_en), .wr_num(wr_num), .wr_data(wr_data), .iss_en(iss_en),
        .iss_num(iss_num), .flush(flush), .err_multiwr(err_multiwr)
    );

    always #5 clk = ~clk;

    task automatic idle();
        rst = 1'b0; rd_num = '0; wr_en = '0; wr_num = '0; wr_data = '0;
        iss_en = 1'b0; iss_num = '0; flush = 1'b0;
    endtask

    task automatic set_rd(input int k, input int idx);
        rd_num[k*AW +: AW] = AW'(idx);
    endtask

    task automatic set_wr(input int p, input int idx, input logic [XLEN-1:0] d);
        wr_en[p]              = 1'b1;
        wr_num[p*AW +: AW]    = AW'(idx);
        wr_data[p*XLEN +: XLEN] = d;
    endtask

    function automatic logic [XLEN-1:0] get_rd(input int k);
        return rd_data[k*XLEN +: XLEN];
    endfunction

    // Expected combinational read: reg 0 reads zero, otherwise the last enabled
    // write port naming the register forwards, otherwise the stored value.
    function automatic logic [XLEN-1:0] exp_data(input int k);
        int idx = int'(rd_num[k*AW +: AW]);
        logic [XLEN-1:0] d = model_regs[idx];
        if (idx == 0) return '0;
        for (int p = 0; p < NWR; p++)
            if (wr_en[p] && int'(wr_num[p*AW +: AW]) == idx) d = wr_data[p*XLEN +: XLEN];
        return d;
    endfunction

    function automatic logic exp_busy(input int k);
        int idx = int'(rd_num[k*AW +: AW]);
        if (idx == 0) return 1'b0;
        for (int p = 0; p < NWR; p++)
            if (wr_en[p] && int'(wr_num[p*AW +: AW]) == idx) return 1'b0;
        return model_busy[idx];
    endfunction

    // Advance the model with the currently driven inputs, then clock the DUT.
    task automatic step();
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                model_regs[r] = '0;
                model_busy[r] = 1'b0;
            end
            model_err = 1'b0;
        end else begin
            for (int r = 1; r < NREG; r++) begin
                int hits = 0;
                for (int p = 0; p < NWR; p++)
                    if (wr_en[p] && int'(wr_num[p*AW +: AW]) == r) hits++;
                if (hits > 1) model_err = 1'b1;
            end
            for (int p = 0; p < NWR; p++) begin
                int idx = int'(wr_num[p*AW +: AW]);
                if (wr_en[p] && idx != 0) begin
                    model_regs[idx] = wr_data[p*XLEN +: XLEN];
                    model_busy[idx] = 1'b0;
                end
            end
            if (flush) begin
                for (int r = 0; r < NREG; r++) model_busy[r] = 1'b0;
            end else if (iss_en && iss_num != '0) begin
                model_busy[iss_num] = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        set_wr(0, 4, 32'hAAAA5555);
        iss_en = 1'b1; iss_num = 5'd4;
        step();
        idle();
        for (int i = 0; i < 4; i++) begin
            set_rd(0, 2*i + 3); set_rd(1, 2*i + 4);
            #1;
            for (int k = 0; k < NRD; k++) begin
                vectors++;
                if (get_rd(k) !== '0 || rd_busy[k] !== 1'b0) begin
                    miscompares++;
                    $display("FAIL reset_read port%0d: got data %h busy %b, expected 0/0", k, get_rd(k), rd_busy[k]);
                end
            end
        end
        vectors++;
        if (err_multiwr !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_err: got %b expected 0", err_multiwr);
        end
    endtask

    task automatic test_write_read();
        idle();
        set_wr(0, 5, 32'hDEADBEEF);
        step();
        idle();
        set_rd(1, 5);
        #1;
        vectors++;
        if (get_rd(1) !== 32'hDEADBEEF || rd_busy[1] !== 1'b0) begin
            miscompares++;
            $display("FAIL write_read: got %h busy %b, expected deadbeef busy 0", get_rd(1), rd_busy[1]);
        end
    endtask

    task automatic test_bypass();
        idle();
        set_wr(1, 7, 32'h12345678);
        set_rd(0, 7);
        #1;
        vectors++;
        if (get_rd(0) !== 32'h12345678 || rd_busy[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL bypass_same_cycle: got %h busy %b, expected 12345678 busy 0", get_rd(0), rd_busy[0]);
        end
        step();
        idle();
        set_rd(1, 7);
        #1;
        vectors++;
        if (get_rd(1) !== 32'h12345678) begin
            miscompares++;
            $display("FAIL bypass_stored: got %h expected 12345678", get_rd(1));
        end
    endtask

    task automatic test_scoreboard();
        idle();
        iss_en = 1'b1; iss_num = 5'd3;
        step();
        idle();
        set_rd(0, 3);
        #1;
        vectors++;
        if (rd_busy[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL sb_issue_busy: got %b expected 1", rd_busy[0]);
        end
        set_wr(0, 3, 32'h55);
        iss_en = 1'b1; iss_num = 5'd3;
        step();
        idle();
        set_rd(0, 3);
        #1;
        vectors++;
        if (get_rd(0) !== 32'h55 || rd_busy[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL sb_write_and_issue: got %h busy %b, expected 55 busy 1", get_rd(0), rd_busy[0]);
        end
        set_wr(1, 3, 32'h55);
        step();
        idle();
        set_rd(1, 3);
        #1;
        vectors++;
        if (get_rd(1) !== 32'h55 || rd_busy[1] !== 1'b0) begin
            miscompares++;
            $display("FAIL sb_complete: got %h busy %b, expected 55 busy 0", get_rd(1), rd_busy[1]);
        end
    endtask

    task automatic test_zero_r0();
        idle();
        set_wr(0, 0, 32'hFFFFFFFF);
        set_wr(1, 0, 32'hFFFFFFFF);
        iss_en = 1'b1; iss_num = '0;
        set_rd(0, 0);
        #1;
        vectors++;
        if (get_rd(0) !== '0 || rd_busy[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL r0_bypass: got %h busy %b, expected 0 busy 0", get_rd(0), rd_busy[0]);
        end
        step();
        idle();
        set_rd(1, 0);
        #1;
        vectors++;
        if (get_rd(1) !== '0 || rd_busy[1] !== 1'b0 || err_multiwr !== 1'b0) begin
            miscompares++;
            $display("FAIL r0_stored: got %h busy %b err %b, expected 0/0/0", get_rd(1), rd_busy[1], err_multiwr);
        end
    endtask

    task automatic test_collision();
        idle();
        set_wr(0, 9, 32'h1);
        set_wr(1, 9, 32'h2);
        step();
        idle();
        set_rd(0, 9);
        #1;
        vectors++;
        if (get_rd(0) !== 32'h2 || err_multiwr !== 1'b1) begin
            miscompares++;
            $display("FAIL collision: got %h err %b, expected 2 err 1", get_rd(0), err_multiwr);
        end
        step(); step(); step();
        vectors++;
        if (err_multiwr !== 1'b1) begin
            miscompares++;
            $display("FAIL collision_sticky: got %b expected 1", err_multiwr);
        end
    endtask

    task automatic test_flush_reset();
        for (int rep = 0; rep < 2; rep++) begin
            idle(); iss_en = 1'b1; iss_num = 5'd2; step();
            idle(); iss_en = 1'b1; iss_num = 5'd4; step();
            idle(); set_rd(0, 2); set_rd(1, 4);
            #1;
            vectors++;
            if (rd_busy !== 2'b11) begin
                miscompares++;
                $display("FAIL flush_pre_busy rep%0d: got %b expected 11", rep, rd_busy);
            end
            if (rep == 0) begin
                flush = 1'b1; iss_en = 1'b1; iss_num = 5'd6;
            end else begin
                rst = 1'b1;
                set_wr(0, 2, 32'hCAFEF00D);
                set_wr(1, 10, 32'h0BADF00D);
                iss_en = 1'b1; iss_num = 5'd6; flush = 1'b1;
            end
            step();
            idle();
            for (int i = 0; i < 3; i++) begin
                set_rd(0, (i == 0) ? 2 : (i == 1) ? 6 : 10);
                set_rd(1, (i == 0) ? 4 : (i == 1) ? 5 : 9);
                #1;
                for (int k = 0; k < NRD; k++) begin
                    vectors++;
                    if (rd_busy[k] !== 1'b0 || (rep == 1 && get_rd(k) !== '0)) begin
                        miscompares++;
                        $display("FAIL flush_rst rep%0d port%0d: got data %h busy %b, expected %s busy 0",
                                 rep, k, get_rd(k), rd_busy[k], (rep == 1) ? "0" : "any");
                    end
                end
            end
            if (rep == 1) begin
                vectors++;
                if (err_multiwr !== 1'b0) begin
                    miscompares++;
                    $display("FAIL rst_clears_err: got %b expected 0", err_multiwr);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            idle();
            rst    = ($urandom_range(0, 39) == 0);
            flush  = ($urandom_range(0, 9) == 0);
            iss_en = $urandom_range(0, 1);
            iss_num = AW'($urandom_range(0, 7));
            for (int p = 0; p < NWR; p++)
                if ($urandom_range(0, 2) != 0) set_wr(p, $urandom_range(0, 7), $urandom);
            for (int k = 0; k < NRD; k++) set_rd(k, $urandom_range(0, 7));
            #1;
            for (int k = 0; k < NRD; k++) begin
                vectors++;
                if (get_rd(k) !== exp_data(k) || rd_busy[k] !== exp_busy(k)) begin
                    miscompares++;
                    $display("FAIL random n%0d port%0d: got data %h busy %b, expected %h busy %b",
                             n, k, get_rd(k), rd_busy[k], exp_data(k), exp_busy(k));
                end
            end
            vectors++;
            if (err_multiwr !== model_err) begin
                miscompares++;
                $display("FAIL random_err n%0d: got %b expected %b", n, err_multiwr, model_err);
            end
            step();
        end
    endtask

    initial begin
        idle();
        @(posedge clk);
        #1;
        test_reset();
        test_write_read();
        test_bypass();
        test_scoreboard();
        test_zero_r0();
        test_collision();
        test_flush_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gprfile_mp.md
GPRFILE_MP -- requirements
Module: gprfile_mp

Interface
REQ-001 Parameter XLEN, default 32, data width of each register.
REQ-002 Parameter NREG, default 32, number of registers; power of two, >= 2; AW = $clog2(NREG).
REQ-003 Parameter NRD, default 2, number of read ports.
REQ-004 Parameter NWR, default 2, number of write ports.
REQ-005 Parameter BYPASS, default 1, 1 = same-cycle write-to-read forwarding.
REQ-006 Parameter ZERO_R0, default 1, 1 = register 0 hardwired to zero.
REQ-007 clk  input  1  sole clock; all state updates on rising edge.
REQ-008 rst  input  1  synchronous, active-high reset.
REQ-009 rd_num  input  NRD*AW  read register indices, port k at bits [k*AW +: AW].
REQ-010 rd_data  output  NRD*XLEN  read data, port k at bits [k*XLEN +: XLEN].
REQ-011 rd_busy  output  NRD  port k's register has an outstanding producer.
REQ-012 wr_en  input  NWR  write enables.
REQ-013 wr_num  input  NWR*AW  write register indices.
REQ-014 wr_data  input  NWR*XLEN  write data.
REQ-015 iss_en  input  1  issue: mark iss_num busy.
REQ-016 iss_num  input  AW  register gaining a new producer.
REQ-017 flush  input  1  clear all busy bits.
REQ-018 err_multiwr  output  1  sticky flag: two enabled write ports targeted one register in the same cycle.

Function
REQ-019 Reads combinational: rd_data[k] = stored value of rd_num[k]; no read latency.
REQ-020 Writes take effect at the rising edge: value visible to non-bypassed reads the following cycle.
REQ-021 Write port collision on one register: highest-index enabled port wins; err_multiwr sets next cycle, holds until rst.
REQ-022 BYPASS=1: if any enabled write targets rd_num[k] this cycle, rd_data[k] = winning write's data and rd_busy[k] = 0.
REQ-023 BYPASS=0: reads return pre-edge stored value; rd_busy reflects stored busy bits only.
REQ-024 ZERO_R0=1: writes and issues to register 0 ignored; reads of 0 return 0 with rd_busy 0, bypass included; never sets err_multiwr.
REQ-025 Scoreboard: one busy bit per register; iss_en sets busy[iss_num] at edge; an enabled write to register r clears busy[r] at edge.
REQ-026 Issue and write to same register in one cycle: busy ends set (new producer wins over old completion).
REQ-027 flush clears all busy bits at edge, overriding same-cycle iss_en; register writes still occur under flush.
REQ-028 Write to a non-busy register is legal: data stored, busy stays 0.
REQ-029 NRD, NWR >= 1; all index widths exactly AW; out-of-range indices impossible by width.

Reset
REQ-030 rst at edge: all registers 0, all busy bits 0, err_multiwr 0; rst overrides same-cycle writes, issues and flush.
REQ-031 During rst cycle outputs stay combinational on pre-edge state; first post-reset cycle: rd_data all 0, rd_busy all 0, err_multiwr 0.
REQ-032 rst mid-operation (busy bits set, collision pending) discards all pending state; no write from the reset cycle survives.

Verification
REQ-033 Reset, then write port0 reg5=0xDEADBEEF; next cycle read port1 reg5 -> 0xDEADBEEF, rd_busy 0.
REQ-034 BYPASS=1: same cycle write port1 reg7=0x12345678, read port0 reg7 -> 0x12345678 that cycle; BYPASS=0 -> old value 0.
REQ-035 Ports 0 and 1 write reg9 with 0x1 and 0x2 together -> reg9=0x2 next cycle, err_multiwr 1 and stays 1 until rst.
REQ-036 iss_en reg3; next cycle read reg3 -> rd_busy 1; write reg3=0x55 with iss_en reg3 same cycle -> reg3=0x55, busy still 1; write again alone -> busy 0.
REQ-037 ZERO_R0=1: write reg0=0xFFFFFFFF, iss_en reg0 -> reads of reg0 return 0, rd_busy 0, no error.
REQ-038 Set busy on reg2 and reg4, assert flush with iss_en reg6 -> all busy 0; repeat then assert rst with writes -> all registers 0, flags clear.
